// File: rtl/mmu_pkg.sv
// Shared constants and types for the MMU front-end feeder.
// The row type packs lane 0 in the least-significant element.
package mmu_pkg;

  localparam int bit_width = 8;
  localparam int acc_width = 32;
  localparam int size      = 4;
  localparam int CNT_W     = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WT,
    STREAM,
    DRAIN
  } feeder_state_t;

  typedef logic [size-1:0][bit_width-1:0] row_t;
  typedef logic [bit_width:0]             lane_word_t;

  // {valid, data}; a bubble always carries a zero element so idle lanes read 0
  function automatic lane_word_t pack_lane(input logic vld, input logic [bit_width-1:0] data);
    return {vld, (vld ? data : {bit_width{1'b0}})};
  endfunction

endpackage

// File: rtl/mmu_feeder_skew_line.sv
// Fixed-depth delay line for one skew lane; valid and data shift as one word.
// Depth 1 is a plain output register.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/mmu_feeder.sv
// Input-side sequencer for the weight-stationary MMU: loads a weight tile,
// then streams diagonally skewed activation rows and drains the skew network.
module mmu_feeder
  import mmu_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wt_valid,
  output logic                           wt_ready,
  input  logic [size-1:0][bit_width-1:0] wt_row,
  input  logic                           act_valid,
  output logic                           act_ready,
  input  logic [size-1:0][bit_width-1:0] act_row,
  input  logic                           act_last,
  output logic                           control,
  output logic [size-1:0][bit_width-1:0] wt_arr,
  output logic [size-1:0][bit_width-1:0] data_arr,
  output logic [size-1:0]                lane_valid,
  output logic                           busy,
  output logic                           done
);

  feeder_state_t    r_state;
  logic [CNT_W-1:0] r_wt_cnt;
  logic [CNT_W-1:0] r_drain_cnt;
  logic             r_control;
  row_t             r_wt_arr;
  logic             r_wt_ready;
  logic             r_act_ready;
  logic             r_busy;
  logic             r_done;

  logic       w_wt_acc;
  logic       w_act_acc;
  lane_word_t w_lane_in  [size];
  lane_word_t w_lane_out [size];

  assign w_wt_acc  = wt_valid  & r_wt_ready;
  assign w_act_acc = act_valid & r_act_ready;

  // Handshake readiness is registered with the state so the ready outputs
  // never depend combinationally on the valid inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wt_cnt    <= '0;
      r_drain_cnt <= '0;
      r_control   <= 1'b0;
      r_wt_arr    <= '0;
      r_wt_ready  <= 1'b0;
      r_act_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_control <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wt_valid) begin
            r_state    <= LOAD_WT;
            r_wt_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_wt_cnt   <= '0;
          end
        end
        LOAD_WT: begin
          if (w_wt_acc) begin
            r_control <= 1'b1;
            r_wt_arr  <= wt_row;
            if (r_wt_cnt == CNT_W'(size - 1)) begin
              r_state     <= STREAM;
              r_wt_ready  <= 1'b0;
              r_act_ready <= 1'b1;
            end else begin
              r_wt_cnt <= r_wt_cnt + CNT_W'(1);
            end
          end
        end
        STREAM: begin
          if (w_act_acc && act_last) begin
            r_state     <= DRAIN;
            r_act_ready <= 1'b0;
            r_drain_cnt <= '0;
          end
        end
        DRAIN: begin
          // done lines up with the last lane of the final row leaving the skew
          if (r_drain_cnt == CNT_W'(size - 2)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_wt_ready  <= 1'b0;
          r_act_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < size; j++) begin
      w_lane_in[j] = pack_lane(w_act_acc, act_row[j]);
    end
  end

  // Lane j sits behind j+1 registers, producing the diagonal wavefront.
  for (genvar j = 0; j < size; j++) begin : g_lane
    skew_line #(
      .DEPTH(j + 1),
      .WIDTH(bit_width + 1)
    ) u_skew (
      .clk   (clk),
      .reset (reset),
      .i_d   (w_lane_in[j]),
      .o_q   (w_lane_out[j])
    );
    assign data_arr[j]   = w_lane_out[j][bit_width-1:0];
    assign lane_valid[j] = w_lane_out[j][bit_width];
  end

  assign control   = r_control;
  assign wt_arr    = r_wt_arr;
  assign wt_ready  = r_wt_ready;
  assign act_ready = r_act_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/mmu_feeder.md
# mmu_feeder

Front-end sequencer that drives the weight-stationary MMU's input side. It accepts un-skewed weight rows and activation rows over valid/ready handshakes. It produces the MMU's `control`/`wt_arr` weight-load sequence and the diagonally skewed `data_arr` stream, then drains and signals completion. It sits between the operand buffers and the MMU, replacing hand-sequenced stimulus.

## Interface
- `bit_width`, 8, operand width
- `size`, 4, array dimension (lanes, weight rows)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `wt_valid`  in  1  weight row valid
- `wt_ready`  out  1  weight row accepted when both high
- `wt_row`  in  `[size-1:0][bit_width]`  one weight row
- `act_valid`  in  1  activation row valid
- `act_ready`  out  1  activation row accepted when both high
- `act_row`  in  `[size-1:0][bit_width]`  one activation row, un-skewed
- `act_last`  in  1  marks final activation row of the batch
- `control`  out  1  MMU weight-shift enable
- `wt_arr`  out  `[size-1:0][bit_width]`  weight row to MMU
- `data_arr`  out  `[size-1:0][bit_width]`  skewed activations to MMU
- `lane_valid`  out  `[size-1:0]`  per lane: `data_arr[j]` carries a real element
- `busy`  out  1  batch in progress
- `done`  out  1  one-cycle pulse when the batch is fully drained

## Operation
- FSM states: IDLE, LOAD_WT, STREAM, DRAIN.
- IDLE:
  - `wt_ready`=0 and `act_ready`=0.
  - A `wt_valid` seen in IDLE moves to LOAD_WT next cycle.
- LOAD_WT:
  - `wt_ready`=1 and `act_ready`=0.
  - Each accepted row is registered onto `wt_arr` with `control`=1 for exactly that one cycle.
  - A gap cycle (no handshake) gives `control`=0 with `wt_arr` held.
  - A row counter counts 0..size-1. Accepting row size-1 moves to STREAM.
- STREAM:
  - `act_ready`=1 and `wt_ready`=0.
  - An accepted row enters the skew network.
  - A cycle with no handshake injects a zero row with valid bits 0 (a bubble).
  - Accepting a row with `act_last` moves to DRAIN.
- DRAIN:
  - Zero rows are injected for size-1 cycles (drain counter).
  - On the final drain cycle the FSM returns to IDLE and asserts `done` that same cycle.
- Skew: lane j delays by j register stages; element and valid bit travel together. Lane 0 has one output register only.
- `busy` = state != IDLE.
- No arithmetic. Operands pass through unmodified at `bit_width`.

## Timing
- Reset, asynchronous and active-low, gives:
  - `control`=0, `wt_arr`=0, `data_arr`=0, `lane_valid`=0.
  - `busy`=0, `done`=0, `wt_ready`=0, `act_ready`=0.
  - State IDLE, all skew stages cleared.
- Reset mid-batch aborts immediately. No `done` is issued, and in-flight skew contents are discarded.
- Weight row accepted at edge t: `control`=1 and `wt_arr`=row during cycle t+1.
- Activation row accepted at edge t: element j appears on `data_arr[j]` during cycle t+1+j.
- Last weight accept at t: `act_ready`=1 from cycle t+1. The earliest data reaches `data_arr` at t+2, by which time `control` is already 0.
- `act_last` accepted at t:
  - Lane size-1 of the last row appears at t+size.
  - `done` pulses and `busy` falls at t+size.
  - `wt_ready` rises at the earliest at t+size+1.
- Back-to-back batches are allowed. A `wt_valid` held high during DRAIN waits and is accepted in LOAD_WT.
- `act_valid` in LOAD_WT or DRAIN is ignored (not accepted). `wt_valid` in STREAM is ignored.
- A batch with a single row flagged `act_last` is legal.

## Structure
- Shared package `mmu_pkg`:
  - `bit_width`, `acc_width` and `size` constants.
  - `feeder_state_t` enum (IDLE/LOAD_WT/STREAM/DRAIN).
  - A row typedef `logic [size-1:0][bit_width-1:0]`.
- Sub-module `skew_line`:
  - Parameterised on depth and width.
  - Carries {valid, data} through a shift register.
  - Instantiated once per lane with depth j+1.

## Test plan
- Weight load: rows (4,3,2,5), (3,2,1,3), (2,1,4,7), (3,4,2,1) held valid back-to-back -> `control`=1 for exactly 4 consecutive cycles with `wt_arr` equal to those rows in order, then `control`=0.
- Skew: rows (1,1,1,2), (2,2,1,4), (0,1,3,5), (0,2,1,0) with `act_last` on the fourth -> `data_arr` reads (1,0,0,0), (2,1,0,0), (0,2,1,0), (0,1,1,2), … on consecutive cycles. `lane_valid` matches. `done` pulses 4 cycles after the last accept.
- Weight gap: `wt_valid` low for 2 cycles after row 1 -> `control`=0 for those 2 cycles, `wt_arr` holds row 1, and the load still completes after 4 accepted rows.
- Activation bubble: `act_valid` low for 1 cycle between rows 0 and 1 -> a zero row is injected, `lane_valid` stays 0 along that diagonal, and later rows shift by one cycle.
- Reset mid-STREAM: assert `reset` low after 2 activation rows -> all outputs go to 0 asynchronously, no `done`, and a fresh batch afterwards runs correctly.
- Back-to-back: `wt_valid` high during DRAIN -> not accepted until the cycle after `done`. The second batch's first `control`=1 follows with no spurious data.
